// File: rtl/compare_cards.sv
// Pair-matching core for the 6x6 memory game: two-card selection, compare, retire, count.
// Optional macro COMPARE_CARDS_LOCKOUT_EN adds a post-mismatch press lockout of LOCKOUT_CYCLES.
module compare_cards #(
    parameter int LOCKOUT_CYCLES = 4
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        A,
    input  logic [2:0]  inputState,
    input  logic [5:0]  mem6x6,
    output logic [4:0]  data1,
    output logic [4:0]  data2,
    output logic        cardOneTwo,
    output logic [31:0] pairsFound,
    output logic        GO
);

    localparam logic [2:0]  PLAY      = 3'd2;
    localparam logic [31:0] ALL_PAIRS = 32'd18;

    if (LOCKOUT_CYCLES < 1) begin : g_bad_cfg
        $error("LOCKOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        FIRST,
        SECOND,
        COMPARE,
`ifdef COMPARE_CARDS_LOCKOUT_EN
        LOCKOUT,
`endif
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        a_q;
    logic [4:0]  data1_q, data1_d, data2_q, data2_d;
    logic [5:0]  cardmem1, cardmem1_d, cardmem2, cardmem2_d;
    logic        card_one_two_q, card_one_two_d;
    logic [31:0] pairs_q, pairs_d;
    logic        go_q, go_d;
    logic [35:0] matched_q, matched_d;
    logic        press, sel_matched, accept;

`ifdef COMPARE_CARDS_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`endif

    // Pair partners sit 18 apart, so the face depends only on pos mod 18.
    function automatic logic [4:0] deck_face(input logic [5:0] pos);
        logic [5:0] m;
        m = (pos >= 6'd18) ? pos - 6'd18 : pos;
        return m[4:0] ^ 5'b01111;
    endfunction

    assign press = A & ~a_q;

    always_comb begin
        sel_matched = 1'b0;
        for (int i = 0; i < 36; i++)
            if (mem6x6 == 6'(i)) sel_matched = matched_q[i];
    end

    assign accept = press && (inputState == PLAY) && (mem6x6 <= 6'd35) && !sel_matched;

    always_comb begin
        state_d        = state_q;
        data1_d        = data1_q;
        data2_d        = data2_q;
        cardmem1_d     = cardmem1;
        cardmem2_d     = cardmem2;
        card_one_two_d = card_one_two_q;
        pairs_d        = pairs_q;
        go_d           = go_q;
        matched_d      = matched_q;
`ifdef COMPARE_CARDS_LOCKOUT_EN
        lock_cnt_d     = lock_cnt_q;
`endif
        case (state_q)
            FIRST: begin
                if (accept) begin
                    cardmem1_d     = mem6x6;
                    data1_d        = deck_face(mem6x6);
                    data2_d        = 5'd0;
                    card_one_two_d = 1'b1;
                    state_d        = SECOND;
                end
            end
            SECOND: begin
                if (accept && (mem6x6 != cardmem1)) begin
                    cardmem2_d     = mem6x6;
                    data2_d        = deck_face(mem6x6);
                    card_one_two_d = 1'b0;
                    state_d        = COMPARE;
                end
            end
            COMPARE: begin
                if (data1_q == data2_q) begin
                    for (int i = 0; i < 36; i++)
                        if ((cardmem1 == 6'(i)) || (cardmem2 == 6'(i))) matched_d[i] = 1'b1;
                    if (pairs_q < ALL_PAIRS) pairs_d = pairs_q + 32'd1;
                    if (pairs_q + 32'd1 >= ALL_PAIRS) begin
                        go_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = FIRST;
                    end
                end else begin
`ifdef COMPARE_CARDS_LOCKOUT_EN
                    lock_cnt_d = '0;
                    state_d    = LOCKOUT;
`else
                    state_d    = FIRST;
`endif
                end
            end
`ifdef COMPARE_CARDS_LOCKOUT_EN
            LOCKOUT: begin
                if (lock_cnt_q == LW'(LOCKOUT_CYCLES - 1)) state_d = FIRST;
                else lock_cnt_d = lock_cnt_q + 1'b1;
            end
`endif
            DONE:    go_d    = 1'b1;
            default: state_d = FIRST;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q        <= FIRST;
            a_q            <= 1'b0;
            data1_q        <= '0;
            data2_q        <= '0;
            cardmem1       <= '0;
            cardmem2       <= '0;
            card_one_two_q <= 1'b0;
            pairs_q        <= '0;
            go_q           <= 1'b0;
            matched_q      <= '0;
`ifdef COMPARE_CARDS_LOCKOUT_EN
            lock_cnt_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            a_q            <= A;
            data1_q        <= data1_d;
            data2_q        <= data2_d;
            cardmem1       <= cardmem1_d;
            cardmem2       <= cardmem2_d;
            card_one_two_q <= card_one_two_d;
            pairs_q        <= pairs_d;
            go_q           <= go_d;
            matched_q      <= matched_d;
`ifdef COMPARE_CARDS_LOCKOUT_EN
            lock_cnt_q     <= lock_cnt_d;
`endif
        end
    end

    assign data1      = data1_q;
    assign data2      = data2_q;
    assign cardOneTwo = card_one_two_q;
    assign pairsFound = pairs_q;
    assign GO         = go_q;

endmodule

// File: tb/tb_compare_cards.sv
// Directed-vector bench for compare_cards: table of presses plus hand-written corner sequences.
module tb_compare_cards;

    logic        clock = 1'b0;
    logic        resetN;
    logic        A;
    logic [2:0]  inputState;
    logic [5:0]  mem6x6;
    logic [4:0]  data1, data2;
    logic        cardOneTwo;
    logic [31:0] pairsFound;
    logic        GO;

    int n_cmp = 0;
    int n_bad = 0;

    compare_cards dut (
        .clock      (clock),
        .resetN     (resetN),
        .A          (A),
        .inputState (inputState),
        .mem6x6     (mem6x6),
        .data1      (data1),
        .data2      (data2),
        .cardOneTwo (cardOneTwo),
        .pairsFound (pairsFound),
        .GO         (GO)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] st;
        logic [5:0] pos;
        logic [4:0] d1;
        logic [4:0] d2;
        logic       c12;
        int         pf;
        logic       go;
        logic [5:0] cm1;
        logic [5:0] cm2;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [2:0] st, input logic [5:0] pos,
                                input logic [4:0] d1, input logic [4:0] d2, input logic c12,
                                input int pf, input logic go, input logic [5:0] cm1,
                                input logic [5:0] cm2);
        vec_t v;
        v.st = st; v.pos = pos; v.d1 = d1; v.d2 = d2; v.c12 = c12;
        v.pf = pf; v.go = go; v.cm1 = cm1; v.cm2 = cm2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] d1, input logic [4:0] d2,
                           input logic c12, input int pf, input logic go,
                           input logic [5:0] cm1, input logic [5:0] cm2);
        chk({tag, ".data1"},      32'(data1),        32'(d1));
        chk({tag, ".data2"},      32'(data2),        32'(d2));
        chk({tag, ".cardOneTwo"}, 32'(cardOneTwo),   32'(c12));
        chk({tag, ".pairsFound"}, pairsFound,        32'(pf));
        chk({tag, ".GO"},         32'(GO),           32'(go));
        chk({tag, ".cardmem1"},   32'(dut.cardmem1), 32'(cm1));
        chk({tag, ".cardmem2"},   32'(dut.cardmem2), 32'(cm2));
    endtask

    // Called at a negedge; returns at the negedge right after the press edge.
    task automatic drive_press(input logic [5:0] p, input logic [2:0] s);
        A = 1'b1; mem6x6 = p; inputState = s;
        @(negedge clock);
        A = 1'b0;
    endtask

    task automatic press(input logic [5:0] p, input logic [2:0] s);
        drive_press(p, s);
        @(negedge clock);
    endtask

    task automatic do_reset();
        A = 1'b0; resetN = 1'b0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int prev_pf;
        vecs[0]  = mk(3'd2, 6'd0,  5'd15, 5'd0,  1'b1, 0, 1'b0, 6'd0, 6'd0);
        vecs[1]  = mk(3'd2, 6'd18, 5'd15, 5'd15, 1'b0, 1, 1'b0, 6'd0, 6'd18);
        vecs[2]  = mk(3'd2, 6'd5,  5'd10, 5'd0,  1'b1, 1, 1'b0, 6'd5, 6'd18);
        vecs[3]  = mk(3'd2, 6'd5,  5'd10, 5'd0,  1'b1, 1, 1'b0, 6'd5, 6'd18);
        vecs[4]  = mk(3'd2, 6'd36, 5'd10, 5'd0,  1'b1, 1, 1'b0, 6'd5, 6'd18);
        vecs[5]  = mk(3'd0, 6'd6,  5'd10, 5'd0,  1'b1, 1, 1'b0, 6'd5, 6'd18);
        vecs[6]  = mk(3'd2, 6'd23, 5'd10, 5'd10, 1'b0, 2, 1'b0, 6'd5, 6'd23);
        vecs[7]  = mk(3'd2, 6'd1,  5'd14, 5'd0,  1'b1, 2, 1'b0, 6'd1, 6'd23);
        vecs[8]  = mk(3'd2, 6'd2,  5'd14, 5'd13, 1'b0, 2, 1'b0, 6'd1, 6'd2);
        vecs[9]  = mk(3'd2, 6'd0,  5'd14, 5'd13, 1'b0, 2, 1'b0, 6'd1, 6'd2);
        vecs[10] = mk(3'd2, 6'd18, 5'd14, 5'd13, 1'b0, 2, 1'b0, 6'd1, 6'd2);
        vecs[11] = mk(3'd2, 6'd1,  5'd14, 5'd0,  1'b1, 2, 1'b0, 6'd1, 6'd2);
        vecs[12] = mk(3'd2, 6'd19, 5'd14, 5'd14, 1'b0, 3, 1'b0, 6'd1, 6'd19);

        A = 1'b0; inputState = 3'd2; mem6x6 = 6'd0; resetN = 1'b0;
        @(negedge clock);
        do_reset();
        chk_all("reset", 5'd0, 5'd0, 1'b0, 0, 1'b0, 6'd0, 6'd0);

        // Compare latency: pairsFound moves only on the edge after card two is captured.
        drive_press(6'd0, 3'd2);
        @(negedge clock);
        drive_press(6'd18, 3'd2);
        chk("latency.data2", 32'(data2), 32'd15);
        chk("latency.pf_before", pairsFound, 32'd0);
        @(negedge clock);
        chk("latency.pf_after", pairsFound, 32'd1);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            press(vecs[i].pos, vecs[i].st);
            chk_all($sformatf("vec%0d", i), vecs[i].d1, vecs[i].d2, vecs[i].c12,
                    vecs[i].pf, vecs[i].go, vecs[i].cm1, vecs[i].cm2);
        end

        // Holding A counts once, even if the cursor moves while held.
        A = 1'b1; mem6x6 = 6'd3; inputState = 3'd2;
        repeat (5) @(negedge clock);
        mem6x6 = 6'd4;
        @(negedge clock);
        A = 1'b0;
        @(negedge clock);
        chk_all("hold", 5'd12, 5'd0, 1'b1, 3, 1'b0, 6'd3, 6'd19);
        press(6'd21, 3'd2);
        chk_all("hold_pair", 5'd12, 5'd12, 1'b0, 4, 1'b0, 6'd3, 6'd21);

        // Reset mid-selection, with a press on the same edge.
        press(6'd7, 3'd2);
        chk("midrst.data1_pre", 32'(data1), 32'd8);
        resetN = 1'b0; A = 1'b1; mem6x6 = 6'd9;
        @(negedge clock);
        A = 1'b0;
        chk_all("midrst", 5'd0, 5'd0, 1'b0, 0, 1'b0, 6'd0, 6'd0);
        resetN = 1'b1;
        @(negedge clock);
        press(6'd9, 3'd2);
        chk_all("midrst_first", 5'd6, 5'd0, 1'b1, 0, 1'b0, 6'd9, 6'd0);

        // Random sweep from a fresh reset.
        do_reset();
        prev_pf = 0;
        for (int it = 0; it < 800; it++) begin
            A          = 1'($urandom_range(0, 1));
            mem6x6     = 6'($urandom_range(0, 36));
            inputState = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            @(negedge clock);
            chk("rand.monotonic", 32'(int'(pairsFound) >= prev_pf), 32'd1);
            chk("rand.le18", 32'(pairsFound <= 32'd18), 32'd1);
            chk("rand.go", 32'(GO), 32'(pairsFound == 32'd18));
            prev_pf = int'(pairsFound);
        end
        A = 1'b0;

        // Full game.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            press(6'(i), 3'd2);
            press(6'(i + 18), 3'd2);
            chk($sformatf("game%0d.pf", i), pairsFound, 32'(i + 1));
            chk($sformatf("game%0d.go", i), 32'(GO), 32'd0);
        end
        press(6'd17, 3'd2);
        drive_press(6'd35, 3'd2);
        chk("game17.pf_before", pairsFound, 32'd17);
        chk("game17.go_before", 32'(GO), 32'd0);
        @(negedge clock);
        chk_all("game_done", 5'd30, 5'd30, 1'b0, 18, 1'b1, 6'd17, 6'd35);
        press(6'd3, 3'd2);
        press(6'd10, 3'd2);
        press(6'd36, 3'd2);
        chk_all("game_frozen", 5'd30, 5'd30, 1'b0, 18, 1'b1, 6'd17, 6'd35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
